loop_buffer_replay: RTL and testbench
=====================================

# loop_buffer_replay

Instruction store and replay engine behind `stream_loop_detector`. It sits beside the IFID register.
- **Fill:** while the detector is in BUFFERING, it captures the instructions fetched for the loop body into an on-chip RAM.
- **Replay:** while the detector asserts `reuse_signal`, it replays the body in order, wrapping at the loop end. This feeds IFID while fetch is blocked.
- **Flush:** a flush from the detector (mispredict) invalidates the buffer.

## Interface
Parameters:
- `DEPTH`, default 32. Instruction entries; must be ≥ 28 (max loop size 27 + closing branch).
- `AW`, default 5. Pointer width; `2**AW == DEPTH`.

Ports:
- `clk` input 1. Clock.
- `reset` input 1. Reset, asynchronous, active-high; clock `clk`.
- `buf_start` input 1. One-cycle pulse: detector entered BUFFERING.
- `wr_valid` input 1. Fetched instruction valid for capture.
- `wr_instr` input 32. Instruction to capture.
- `wr_pc` input 32. PC of `wr_instr`.
- `buf_close` input 1. One-cycle pulse: closing back-branch reached; this is the detector's `block_signal` rise.
- `reuse_en` input 1. Level; detector `reuse_signal`.
- `flush` input 1. Level or pulse; detector `flush`.
- `rd_ready` input 1. IFID can accept (not stalled).
- `rd_valid` output 1. Replayed instruction valid.
- `rd_instr` output 32. Replayed instruction.
- `rd_pc` output 32. PC of replayed instruction.
- `loaded` output 1. Buffer holds a closed loop.
- `overflow` output 1. Capture exceeded `DEPTH`. Sticky until `buf_start`, `flush` or `reset`.
- `iter_count` output 16. Completed replay laps.

## Operation
States: IDLE, FILL, READY, REPLAY. Event priority: `reset` > `flush` > `buf_start` > all others.

- **IDLE**
  - `buf_start` → FILL; `wptr` = 0, `overflow` = 0, `iter_count` = 0.
  - All other inputs are ignored.
- **FILL**
  - `wr_valid` with `wptr < DEPTH`: write `{wr_pc, wr_instr}` to `mem[wptr]`, then `wptr++`. `wptr` is AW+1 bits wide, so it reaches `DEPTH` without wrapping.
  - `wr_valid` with `wptr == DEPTH`: `overflow` = 1 and go to IDLE (loop too large).
  - `buf_close`: loop length `len` = `wptr` plus 1 if `wr_valid` is asserted in the same cycle; that entry is written.
    - If `len == 0`, go to IDLE.
    - Otherwise go to READY with `loaded` = 1.
  - `buf_start` again: restart the fill with `wptr` = 0.
- **READY**
  - `reuse_en`: go to REPLAY. At the same edge, load `rd_instr`/`rd_pc` from `mem[0]`, set `rd_valid` = 1 and `rptr` = 1 mod `len`.
- **REPLAY**
  - On the handshake (`rd_valid & rd_ready`): load the output registers from `mem[rptr]`; `rptr` = (`rptr` + 1) mod `len`.
  - When the handshaken entry is `len`−1, `iter_count++`. It saturates at 0xFFFF.
  - `reuse_en` low: go to READY, with `rd_valid` = 0 at the next edge. `loaded` stays 1, so a later `reuse_en` restarts at entry 0.
- **flush, any state**
  - Go to IDLE. `rd_valid`, `loaded`, `wptr`, `rptr` and `iter_count` are cleared at the next edge.
  - `overflow` is cleared.
- RAM contents are never reset; validity is tracked only by `len` and `loaded`.
- Read and write never occur in the same cycle (they happen in disjoint states). A single-port RAM is sufficient.

## Timing
- Reset values: `rd_valid` = 0, `rd_instr` = 0, `rd_pc` = 0, `loaded` = 0, `overflow` = 0, `iter_count` = 0; state IDLE.
- All outputs are registered.
- Capture: 0-cycle acceptance; the write happens at the sampling edge. There is no backpressure on the write side.
- Replay start latency: 1 cycle. `reuse_en` is sampled high in READY at edge N; `rd_valid` = 1 with entry 0 after edge N.
- Throughput: 1 instruction per cycle while `rd_ready` = 1.
- While `rd_ready` = 0, `rd_instr`, `rd_pc` and `rd_valid` are held stable.
- `len == 1`: entry 0 is replayed every cycle, and `iter_count` increments on every handshake.
- `flush` asserted together with a handshake: the flush wins and no further entry is presented.

## Configuration
- `LOOP_BUF_ITER_CNT_EN` defined: the `iter_count` logic is built as described above.
- `LOOP_BUF_ITER_CNT_EN` undefined: `iter_count` is tied to 0 and no counter flops are built. All other behaviour is identical.

## Test plan
- **Basic replay:** fill entries with PCs 0x100–0x10C and instructions 0xA0–0xA3, pulse `buf_close`, then hold `reuse_en` = 1 and `rd_ready` = 1.
  - Required: output sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, …
  - Required: after 12 handshakes, `iter_count` = 3 (with `LOOP_BUF_ITER_CNT_EN`).
- **Backpressure:** drop `rd_ready` for 3 cycles while 0xA2 is presented.
  - Required: 0xA2 is held for all 3 cycles, then 0xA3 follows; no entry is skipped or duplicated.
- **Overflow:** `DEPTH` = 32 with 33 consecutive `wr_valid`.
  - Required: after the 33rd, `overflow` = 1, state IDLE, `loaded` = 0; a later `reuse_en` produces no `rd_valid`.
- **Flush mid-replay:** assert `flush` while entry 2 is presented.
  - Required: next cycle `rd_valid` = 0, `loaded` = 0, `iter_count` = 0; a subsequent `reuse_en` is ignored.
- **Close boundary cases:**
  - `buf_close` together with the 3rd `wr_valid`: required `len` = 3, and 3 entries replay.
  - `buf_close` with no entries captured: required return to IDLE with `loaded` = 0.
- **Async reset mid-FILL and mid-REPLAY:** all outputs go to 0 before the next clock edge; state IDLE.

Source files
------------

// File: rtl/loop_buffer_replay.sv
// loop_buffer_replay: instruction store and replay engine for the stream loop
// detector. It captures the fetched loop body while the detector is buffering,
// then replays it in order (wrapping at the loop end) to IFID while fetch is
// blocked. A flush from the detector invalidates the buffer.
//
// Optional feature macro: LOOP_BUF_ITER_CNT_EN builds the replay lap counter;
// when undefined, iter_count is tied to 0.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   buf_start             pulse: (re)start capturing a loop body
//   wr_valid/instr/pc     fetched instruction to capture
//   buf_close             pulse: closing back-branch reached
//   reuse_en              level: replay the captured loop
//   flush                 invalidate buffer, return to idle
//   rd_ready              IFID can accept
//   rd_valid/instr/pc     replayed instruction (registered)
//   loaded                buffer holds a closed loop
//   overflow              capture exceeded DEPTH (sticky)
//   iter_count            completed replay laps (saturating)
module loop_buffer_replay #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        buf_start,
  input  logic        wr_valid,
  input  logic [31:0] wr_instr,
  input  logic [31:0] wr_pc,
  input  logic        buf_close,
  input  logic        reuse_en,
  input  logic        flush,
  input  logic        rd_ready,
  output logic        rd_valid,
  output logic [31:0] rd_instr,
  output logic [31:0] rd_pc,
  output logic        loaded,
  output logic        overflow,
  output logic [15:0] iter_count
);

  localparam int unsigned PW = AW + 1;
  localparam int unsigned DW = 64;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY, S_REPLAY} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] len_q, len_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic          rd_valid_q, rd_valid_d;
  logic [31:0]   rd_instr_q, rd_instr_d;
  logic [31:0]   rd_pc_q, rd_pc_d;
  logic          loaded_q, loaded_d;
  logic          overflow_q, overflow_d;

  logic          mem_we;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] mem [DEPTH];

  logic          hs;
  logic [PW-1:0] rptr_inc;
  logic [AW-1:0] rptr_wrap;

  assign hs        = rd_valid_q & rd_ready;
  assign rptr_inc  = PW'(rptr_q) + PW'(1);
  assign rptr_wrap = (rptr_inc == len_q) ? '0 : rptr_inc[AW-1:0];
  // Replay always starts at entry 0; otherwise read the next pointer.
  assign mem_raddr = (state_q == S_READY) ? '0 : rptr_q;
  assign mem_rdata = mem[mem_raddr];

  // Loop body storage; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wptr_q[AW-1:0]] <= {wr_pc, wr_instr};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    len_d      = len_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    rd_instr_d = rd_instr_q;
    rd_pc_d    = rd_pc_q;
    loaded_d   = loaded_q;
    overflow_d = overflow_q;
    mem_we     = 1'b0;

    if (flush || buf_start) begin
      state_d    = flush ? S_IDLE : S_FILL;
      wptr_d     = '0;
      rptr_d     = '0;
      rd_valid_d = 1'b0;
      loaded_d   = 1'b0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        S_FILL: begin
          if (wr_valid && (wptr_q == PW'(DEPTH))) begin
            overflow_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            if (wr_valid) begin
              mem_we = 1'b1;
              wptr_d = wptr_q + PW'(1);
            end
            if (buf_close) begin
              // Same-cycle capture counts toward the loop length.
              len_d = wptr_q + PW'(wr_valid);
              if (len_d == '0) begin
                state_d = S_IDLE;
              end else begin
                state_d  = S_READY;
                loaded_d = 1'b1;
              end
            end
          end
        end
        S_READY: begin
          if (reuse_en) begin
            state_d    = S_REPLAY;
            rd_valid_d = 1'b1;
            rd_instr_d = mem_rdata[31:0];
            rd_pc_d    = mem_rdata[63:32];
            rptr_d     = (len_q == PW'(1)) ? '0 : AW'(1);
          end
        end
        S_REPLAY: begin
          if (!reuse_en) begin
            state_d    = S_READY;
            rd_valid_d = 1'b0;
          end else if (hs) begin
            rd_instr_d = mem_rdata[31:0];
            rd_pc_d    = mem_rdata[63:32];
            rptr_d     = rptr_wrap;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      len_q      <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_instr_q <= '0;
      rd_pc_q    <= '0;
      loaded_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      len_q      <= len_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_instr_q <= rd_instr_d;
      rd_pc_q    <= rd_pc_d;
      loaded_q   <= loaded_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef LOOP_BUF_ITER_CNT_EN
  logic [15:0] iter_q, iter_d;
  logic        iter_inc;

  // rptr already points past the handshaken entry; zero means it was the last.
  assign iter_inc = (state_q == S_REPLAY) & reuse_en & hs & (rptr_q == '0)
                  | (state_q == S_REPLAY) & ~reuse_en & hs & (rptr_q == '0);

  always_comb begin
    iter_d = iter_q;
    if (flush || buf_start) iter_d = '0;
    else if (iter_inc && (iter_q != 16'hFFFF)) iter_d = iter_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) iter_q <= '0;
    else       iter_q <= iter_d;
  end

  assign iter_count = iter_q;
`else
  assign iter_count = '0;
`endif

  assign rd_valid = rd_valid_q;
  assign rd_instr = rd_instr_q;
  assign rd_pc    = rd_pc_q;
  assign loaded   = loaded_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_loop_buffer_replay.sv
// Testbench for loop_buffer_replay: a vector table for basic replay,
// backpressure and flush, hand-written corner sequences, and randomized
// stimulus checked against a queue-based reference model.
module tb_loop_buffer_replay;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bs = 1'b0, wv = 1'b0, bc = 1'b0, ru = 1'b0, fl = 1'b0, rr = 1'b0;
  logic [31:0] wi = '0, wp = '0;
  logic        rd_valid, loaded, overflow;
  logic [31:0] rd_instr, rd_pc;
  logic [15:0] iter_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  loop_buffer_replay #(.DEPTH(32), .AW(5)) dut (
    .clk(clk), .reset(reset), .buf_start(bs), .wr_valid(wv), .wr_instr(wi),
    .wr_pc(wp), .buf_close(bc), .reuse_en(ru), .flush(fl), .rd_ready(rr),
    .rd_valid(rd_valid), .rd_instr(rd_instr), .rd_pc(rd_pc), .loaded(loaded),
    .overflow(overflow), .iter_count(iter_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_iter(input int v);
`ifdef LOOP_BUF_ITER_CNT_EN
    return 16'(v);
`else
    return 16'(v * 0);
`endif
  endfunction

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 capturing, 2 loop held, 3 replaying
  int          m_mode;
  logic [63:0] m_body[$];
  int          m_pos;
  bit          m_valid, m_loaded, m_ovf;
  logic [31:0] m_instr, m_pc;
  int          m_iter;

  task automatic model_reset();
    m_mode = 0; m_body.delete(); m_pos = 0; m_valid = 0; m_loaded = 0;
    m_ovf = 0; m_instr = '0; m_pc = '0; m_iter = 0;
  endtask

  task automatic model_step();
    if (fl || bs) begin
      m_mode = fl ? 0 : 1; m_valid = 0; m_loaded = 0; m_ovf = 0; m_iter = 0;
      m_body.delete();
    end else begin
      case (m_mode)
        1: begin
          if (wv && m_body.size() == DEPTH) begin
            m_ovf = 1; m_mode = 0;
          end else begin
            if (wv) m_body.push_back({wp, wi});
            if (bc) begin
              if (m_body.size() == 0) m_mode = 0;
              else begin m_mode = 2; m_loaded = 1; end
            end
          end
        end
        2: if (ru) begin
          m_mode = 3; m_pos = 0; m_valid = 1; {m_pc, m_instr} = m_body[0];
        end
        3: begin
          if (m_valid && rr && m_pos == m_body.size() - 1 && m_iter < 65535) m_iter++;
          if (!ru) begin
            m_mode = 2; m_valid = 0;
          end else if (rr) begin
            m_pos = (m_pos + 1) % m_body.size();
            {m_pc, m_instr} = m_body[m_pos];
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(m_valid));
    chk({tag, ".loaded"}, 32'(loaded), 32'(m_loaded));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".iter_count"}, 32'(iter_count), 32'(exp_iter(m_iter)));
    if (m_valid) begin
      chk({tag, ".rd_instr"}, rd_instr, m_instr);
      chk({tag, ".rd_pc"}, rd_pc, m_pc);
    end
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk); #1;
    compare_model(tag);
  endtask

  task automatic idle_inputs();
    bs = 0; wv = 0; bc = 0; ru = 0; fl = 0; rr = 0; wi = '0; wp = '0;
  endtask

  // Asynchronous reset pulse between edges; outputs must clear without a clock.
  task automatic async_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, ".rst_instr"}, rd_instr, 32'd0);
    chk({tag, ".rst_pc"}, rd_pc, 32'd0);
    chk({tag, ".rst_loaded"}, 32'(loaded), 32'd0);
    chk({tag, ".rst_ovf"}, 32'(overflow), 32'd0);
    chk({tag, ".rst_iter"}, 32'(iter_count), 32'd0);
    #1 reset = 1'b0;
    idle_inputs();
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit bs, wv; logic [31:0] wi, wp; bit bc, ru, fl, rr;
    bit ev; logic [31:0] ei; bit el, eo; int eit;
  } vec_t;
  vec_t vt[$];

  task automatic add(input bit b_s, input bit w_v, input logic [31:0] w_i, input logic [31:0] w_p,
                     input bit b_c, input bit r_u, input bit f_l, input bit r_r,
                     input bit e_v, input logic [31:0] e_i, input bit e_l, input bit e_o, input int e_it);
    vec_t v;
    v.bs = b_s; v.wv = w_v; v.wi = w_i; v.wp = w_p; v.bc = b_c; v.ru = r_u; v.fl = f_l; v.rr = r_r;
    v.ev = e_v; v.ei = e_i; v.el = e_l; v.eo = e_o; v.eit = e_it;
    vt.push_back(v);
  endtask

  initial begin
    logic [31:0] first_instr;

    // Reset values
    @(posedge clk); #1;
    chk("reset.rd_valid", 32'(rd_valid), 32'd0);
    chk("reset.rd_instr", rd_instr, 32'd0);
    chk("reset.rd_pc", rd_pc, 32'd0);
    chk("reset.loaded", 32'(loaded), 32'd0);
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.iter", 32'(iter_count), 32'd0);
    #2 reset = 1'b0;
    model_reset();

    // Basic replay, backpressure on 0xA2, then flush while entry 2 is presented.
    add(1,0,0,0, 0,0,0,0, 0,0,0,0,0);
    for (int k = 0; k < 4; k++)
      add(0,1,32'hA0 + 32'(k),32'h100 + 32'(4*k), 0,0,0,0, 0,0,0,0,0);
    add(0,0,0,0, 1,0,0,0, 0,0,1,0,0);
    add(0,0,0,0, 0,1,0,1, 1,32'hA0,1,0,0);
    add(0,0,0,0, 0,1,0,1, 1,32'hA1,1,0,0);
    add(0,0,0,0, 0,1,0,1, 1,32'hA2,1,0,0);
    for (int k = 0; k < 3; k++)
      add(0,0,0,0, 0,1,0,0, 1,32'hA2,1,0,0);
    add(0,0,0,0, 0,1,0,1, 1,32'hA3,1,0,0);
    for (int k = 13; k <= 23; k++)
      add(0,0,0,0, 0,1,0,1, 1,32'hA0 + 32'((k-13)%4),1,0,1 + (k-13)/4);
    add(0,0,0,0, 0,1,1,1, 0,0,0,0,0);
    add(0,0,0,0, 0,1,0,1, 0,0,0,0,0);

    foreach (vt[i]) begin
      bs = vt[i].bs; wv = vt[i].wv; wi = vt[i].wi; wp = vt[i].wp;
      bc = vt[i].bc; ru = vt[i].ru; fl = vt[i].fl; rr = vt[i].rr;
      @(posedge clk); #1;
      chk($sformatf("vec%0d.rd_valid", i), 32'(rd_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d.loaded", i), 32'(loaded), 32'(vt[i].el));
      chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(vt[i].eo));
      chk($sformatf("vec%0d.iter", i), 32'(iter_count), 32'(exp_iter(vt[i].eit)));
      if (vt[i].ev) chk($sformatf("vec%0d.rd_instr", i), rd_instr, vt[i].ei);
    end
    idle_inputs();
    async_reset("post_table");

    // Overflow: 33 consecutive captures.
    bs = 1; cycle("ovf.start"); bs = 0;
    for (int k = 0; k < 33; k++) begin
      wv = 1; wi = 32'h5000 + 32'(k); wp = 32'h8000 + 32'(4*k);
      cycle($sformatf("ovf.w%0d", k));
    end
    wv = 0;
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.loaded", 32'(loaded), 32'd0);
    ru = 1; rr = 1;
    for (int k = 0; k < 3; k++) begin
      cycle("ovf.reuse");
      chk("ovf.no_valid", 32'(rd_valid), 32'd0);
    end
    idle_inputs();

    // Close together with the third capture: three entries replay.
    bs = 1; cycle("c3.start"); bs = 0;
    for (int k = 0; k < 3; k++) begin
      wv = 1; wi = 32'hC0 + 32'(k); wp = 32'h200 + 32'(4*k); bc = (k == 2);
      cycle($sformatf("c3.w%0d", k));
    end
    wv = 0; bc = 0;
    chk("c3.loaded", 32'(loaded), 32'd1);
    ru = 1; rr = 1;
    for (int k = 0; k < 7; k++) begin
      cycle($sformatf("c3.rep%0d", k));
      chk($sformatf("c3.seq%0d", k), rd_instr, 32'hC0 + 32'(k % 3));
    end
    idle_inputs();
    cycle("c3.stop");

    // Close with nothing captured.
    bs = 1; cycle("c0.start"); bs = 0;
    bc = 1; cycle("c0.close"); bc = 0;
    chk("c0.loaded", 32'(loaded), 32'd0);
    ru = 1; rr = 1; cycle("c0.reuse");
    chk("c0.no_valid", 32'(rd_valid), 32'd0);
    idle_inputs();

    // Single-entry loop: same entry every cycle, one lap per handshake.
    bs = 1; cycle("l1.start"); bs = 0;
    wv = 1; bc = 1; wi = 32'hD00D; wp = 32'h300; cycle("l1.close");
    wv = 0; bc = 0; ru = 1; rr = 1;
    cycle("l1.first");
    first_instr = rd_instr;
    chk("l1.instr", first_instr, 32'hD00D);
    for (int k = 1; k <= 4; k++) begin
      cycle($sformatf("l1.rep%0d", k));
      chk($sformatf("l1.iter%0d", k), 32'(iter_count), 32'(exp_iter(k)));
    end
    idle_inputs();

    // Async reset mid-replay and mid-fill.
    async_reset("mid_replay");
    bs = 1; cycle("mf.start"); bs = 0;
    for (int k = 0; k < 5; k++) begin
      wv = 1; wi = 32'hE0 + 32'(k); wp = 32'h400 + 32'(4*k); cycle("mf.w");
    end
    async_reset("mid_fill");

    // Randomized stimulus against the reference model.
    for (int c = 0; c < 3000; c++) begin
      bs = ($urandom_range(0, 39) == 0);
      wv = ($urandom_range(0, 99) < 70);
      wi = $urandom; wp = $urandom;
      bc = ($urandom_range(0, 99) < 8);
      if ($urandom_range(0, 7) == 0) ru = ~ru;
      fl = ($urandom_range(0, 63) == 0);
      rr = ($urandom_range(0, 99) < 70);
      cycle($sformatf("rnd%0d", c));
    end
    idle_inputs();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
